// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
// Moore phase controller for a main road / crossroad intersection.
// The state register steps green -> yellow -> all-red for each road in turn,
// advancing only on the end input that belongs to the current phase.
// All outputs are decoded from the state register alone, so an end input
// never reaches a lamp combinationally.
// Despite its name, rst_n is an active-high synchronous reset that parks
// the controller in the second all-red phase.
module traffic_light_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       green_end,
    input  logic       yellow_end,
    input  logic       red_end,
    output logic [2:0] light_mainroad,
    output logic [2:0] light_crossroad,
    output logic       state_green,
    output logic       state_yellow,
    output logic       state_red
);

    localparam logic [2:0] MAIN_GREEN   = 3'd0;
    localparam logic [2:0] MAIN_YELLOW  = 3'd1;
    localparam logic [2:0] ALL_RED_1    = 3'd2;
    localparam logic [2:0] CROSS_GREEN  = 3'd3;
    localparam logic [2:0] CROSS_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_2    = 3'd5;

    // One-hot lamp patterns {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic [2:0] state;
    logic [2:0] state_next;

    // Next-state selection: only the end input of the current phase is looked at
    always_comb begin
        state_next = state;
        case (state)
            MAIN_GREEN:   if (green_end)  state_next = MAIN_YELLOW;
            MAIN_YELLOW:  if (yellow_end) state_next = ALL_RED_1;
            ALL_RED_1:    if (red_end)    state_next = CROSS_GREEN;
            CROSS_GREEN:  if (green_end)  state_next = CROSS_YELLOW;
            CROSS_YELLOW: if (yellow_end) state_next = ALL_RED_2;
            ALL_RED_2:    if (red_end)    state_next = MAIN_GREEN;
            // Unused encodings recover into the safe all-red phase
            default:                      state_next = ALL_RED_2;
        endcase
    end

    // State register with synchronous reset into all-red
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ALL_RED_2;
        end else begin
            state <= state_next;
        end
    end

    // Output decode from the state register; unknown states show all red
    always_comb begin
        light_mainroad  = LAMP_RED;
        light_crossroad = LAMP_RED;
        state_green     = 1'b0;
        state_yellow    = 1'b0;
        state_red       = 1'b0;
        case (state)
            MAIN_GREEN: begin
                light_mainroad = LAMP_GREEN;
                state_green    = 1'b1;
            end
            MAIN_YELLOW: begin
                light_mainroad = LAMP_YELLOW;
                state_yellow   = 1'b1;
            end
            CROSS_GREEN: begin
                light_crossroad = LAMP_GREEN;
                state_green     = 1'b1;
            end
            CROSS_YELLOW: begin
                light_crossroad = LAMP_YELLOW;
                state_yellow    = 1'b1;
            end
            default: begin
                state_red = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm
// Directed phase walk followed by randomized end/reset stimulus, checked
// against a phase-index model of the intersection cycle.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       green_end;
    logic       yellow_end;
    logic       red_end;
    logic [2:0] light_mainroad;
    logic [2:0] light_crossroad;
    logic       state_green;
    logic       state_yellow;
    logic       state_red;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase position 0..5 in the cycle
    // 0 main green, 1 main yellow, 2 all red, 3 cross green, 4 cross yellow, 5 all red
    int phase = 5;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .green_end       (green_end),
        .yellow_end      (yellow_end),
        .red_end         (red_end),
        .light_mainroad  (light_mainroad),
        .light_crossroad (light_crossroad),
        .state_green     (state_green),
        .state_yellow    (state_yellow),
        .state_red       (state_red)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t phase=%0d)", tag, obs, exp, $time, phase);
        end
    endtask

    task automatic verify_outputs();
        logic [2:0] exp_main;
        logic [2:0] exp_cross;
        logic [2:0] exp_flags;
        logic       road_is_main;
        int         sub;
        road_is_main = (phase < 3);
        sub          = phase % 3;
        // sub: 0 green, 1 yellow, 2 all red
        exp_flags = (sub == 0) ? 3'b100 : (sub == 1) ? 3'b010 : 3'b001;
        exp_main  = 3'b100;
        exp_cross = 3'b100;
        if (sub != 2) begin
            if (road_is_main) exp_main  = (sub == 0) ? 3'b001 : 3'b010;
            else              exp_cross = (sub == 0) ? 3'b001 : 3'b010;
        end
        check_val("main_lamps", {5'd0, light_mainroad}, {5'd0, exp_main});
        check_val("cross_lamps", {5'd0, light_crossroad}, {5'd0, exp_cross});
        check_val("flags_gyr", {5'd0, state_green, state_yellow, state_red}, {5'd0, exp_flags});
        check_val("lamps_onehot", {6'd0, $onehot(light_mainroad), $onehot(light_crossroad)}, 8'h03);
        check_val("both_nonred", {7'd0, (light_mainroad != 3'b100) && (light_crossroad != 3'b100)}, 8'h00);
    endtask

    // Apply inputs for one clock, advance the model, check after the edge
    task automatic step(input logic r, input logic g, input logic y, input logic rd);
        logic adv;
        rst_n      = r;
        green_end  = g;
        yellow_end = y;
        red_end    = rd;
        @(posedge clk);
        if (r) begin
            phase = 5;
        end else begin
            case (phase % 3)
                0:       adv = g;
                1:       adv = y;
                default: adv = rd;
            endcase
            if (adv) phase = (phase + 1) % 6;
        end
        @(negedge clk);
        verify_outputs();
    endtask

    initial begin
        // Reset held, then idle
        repeat (5)  step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full cycle with single-clock pulses and idle gaps
        step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);

        // In main green: non-matching ends ignored, then held green_end+red_end
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // All ends held high from reset release: one step per clock
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (14) step(1'b0, 1'b1, 1'b1, 1'b1);

        // Reset mid-phase in cross green with green_end asserted
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized ends with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
Phase controller for a two-road intersection: main road and crossroad. A Moore state machine steps through green, yellow and all-red phases for each road. External phase timers report expiry through green_end, yellow_end and red_end. The block drives both lamp sets and tells the timer block which phase timer to run (state_green / state_red / state_yellow).

Parameters:
None. State encoding is internal: 3-bit binary, six states.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-high; port name kept per codebase convention; sampled on rising clk edge
green_end  input  1  level; green phase timer expired
yellow_end  input  1  level; yellow phase timer expired
red_end  input  1  level; all-red clearance timer expired
light_mainroad  output  3  main-road lamps, one-hot {red,yellow,green}: 100=red, 010=yellow, 001=green
light_crossroad  output  3  crossroad lamps, same encoding
state_green  output  1  high while in a green phase; enables the green timer
state_yellow  output  1  high while in a yellow phase; enables the yellow timer
state_red  output  1  high while in an all-red phase; enables the red timer

Behaviour:
States, with main/cross lamps and the active state_* flag:
- MAIN_GREEN: main 001, cross 100, state_green=1
- MAIN_YELLOW: main 010, cross 100, state_yellow=1
- ALL_RED_1: main 100, cross 100, state_red=1
- CROSS_GREEN: main 100, cross 001, state_green=1
- CROSS_YELLOW: main 100, cross 010, state_yellow=1
- ALL_RED_2: main 100, cross 100, state_red=1

Transitions, evaluated at each rising clk edge when rst_n=0:
- MAIN_GREEN -> MAIN_YELLOW on green_end
- MAIN_YELLOW -> ALL_RED_1 on yellow_end
- ALL_RED_1 -> CROSS_GREEN on red_end
- CROSS_GREEN -> CROSS_YELLOW on green_end
- CROSS_YELLOW -> ALL_RED_2 on yellow_end
- ALL_RED_2 -> MAIN_GREEN on red_end
- Otherwise the state holds.

Input qualification:
- Only the end input matching the current phase is examined. The other end inputs are ignored, even when asserted simultaneously.
- At most one transition per clock.
- If an end input stays high, the FSM advances once per cycle through each state whose end input is high. Example: green_end and yellow_end both held high from MAIN_GREEN gives MAIN_YELLOW, then ALL_RED_1 one cycle later.

Reset:
- rst_n=1 at a rising edge forces ALL_RED_2, overriding any transition and taking effect mid-phase too.
- Outputs after reset: light_mainroad=100, light_crossroad=100, state_red=1, state_green=0, state_yellow=0.
- While reset is held, the state stays ALL_RED_2.

Outputs and timing:
- All outputs are decoded combinationally from the state register only (no input-to-output path).
- Outputs change one clock after the qualifying end input is sampled high.
- Exactly one of state_green, state_yellow, state_red is high in every state.

Safety invariants:
- At most one road is non-red in any state.
- Each lamp vector is always one-hot.
- Unused state encodings go to ALL_RED_2 on the next clock.

Test Plan:
1. Hold rst_n=1 for 5 clocks, end inputs 0 -> lamps main=100, cross=100; state_red=1, others 0. Release reset with ends still 0 -> state holds for 10 clocks.
2. From ALL_RED_2, pulse red_end for 1 clock -> next cycle main=001, cross=100, state_green=1. Then pulse green_end -> main=010, state_yellow=1. Then pulse yellow_end -> main=100, cross=100, state_red=1.
3. Continue with red_end, green_end, yellow_end, red_end pulses:
   - red_end -> cross=001, main=100
   - green_end -> cross=010
   - yellow_end -> all red
   - red_end -> main=001
   Checks: the full 6-state cycle, one-hot lamps, and never both roads non-red.
4. In MAIN_GREEN, assert red_end and yellow_end (green_end=0) for 5 clocks -> state unchanged, main=001. Then green_end=red_end=1 held -> MAIN_YELLOW and stays there until yellow_end.
5. Hold green_end=yellow_end=red_end=1 continuously from reset release -> state advances every clock: MAIN_GREEN, MAIN_YELLOW, ALL_RED_1, CROSS_GREEN, and so on; period 6 clocks.
6. Assert rst_n=1 for 1 clock while in CROSS_GREEN with green_end=1 -> next cycle ALL_RED_2 (both 100, state_red=1), not CROSS_YELLOW.
